bcd_serial_subtractor: RTL

Digit-serial signed BCD subtractor that computes A − B over DIGITS packed BCD digits. The subtrahend is first converted to nine's complement and added to A with carry-in 1, giving the ten's-complement sum. If the sum has no final carry, the result is converted back from ten's complement to produce sign-magnitude output. The block sits downstream of the digit-complement logic in the decimal arithmetic path and gives the datapath a real subtraction result instead of a raw complemented digit.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_adder.sv | 28 ++
 rtl/bcd_serial_subtractor.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg : shared BCD widths, FSM state encoding and digit helpers
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    RECOMP = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] d);
    return 4'd9 - d;
  endfunction

  function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adder.sv
// ============================================================================
// bcd_digit_adder : combinational single-digit BCD adder with decimal carry
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  // Worst case 9 + 9 + 1 = 19 needs five bits.
  logic [BCD_W:0] raw;
  logic [BCD_W:0] adj;

  assign raw  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
  assign cout = (raw > 5'd9);
  assign adj  = cout ? (raw - 5'd10) : raw;
  assign sum  = adj[BCD_W-1:0];

endmodule

`default_nettype wire

// File: rtl/bcd_serial_subtractor.sv
// ============================================================================
// bcd_serial_subtractor : digit-serial signed BCD A - B, sign-magnitude result
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   Result,
  output logic                  Sign,
  output logic                  Err
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = $clog2(DIGITS + 1);

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       a_sr;
  logic [W-1:0]       b_sr;
  logic [W-1:0]       w_sr;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               neg;
  logic               err_flag;

  logic               in_err;
  logic               last;
  logic [BCD_W-1:0]   op_a;
  logic [BCD_W-1:0]   op_b;
  logic [BCD_W-1:0]   add_sum;
  logic               add_cout;
  logic [W-1:0]       w_shifted;

  always_comb begin
    in_err = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!bcd_valid(A[k*BCD_W +: BCD_W]) || !bcd_valid(B[k*BCD_W +: BCD_W]))
        in_err = 1'b1;
    end
  end

  assign last = (idx == IDX_W'(DIGITS - 1));
  assign busy = (state != IDLE);

  // One adder serves both passes: ADD takes A + (9 - B), RECOMP takes (9 - W) + 0.
  always_comb begin
    op_a = a_sr[BCD_W-1:0];
    op_b = nines_comp(b_sr[BCD_W-1:0]);
    if (state == RECOMP) begin
      op_a = nines_comp(w_sr[BCD_W-1:0]);
      op_b = '0;
    end
  end

  bcd_digit_adder u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // New digit enters at the top so digit 0 ends up at the bottom after DIGITS shifts.
  assign w_shifted = W'({add_sum, w_sr} >> BCD_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = in_err ? DONE : ADD;
      ADD:     if (last)  state_nxt = add_cout ? DONE : RECOMP;
      RECOMP:  if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      w_sr     <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      neg      <= 1'b0;
      err_flag <= 1'b0;
      done     <= 1'b0;
      Result   <= '0;
      Sign     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr     <= A;
            b_sr     <= B;
            w_sr     <= '0;
            idx      <= '0;
            carry    <= 1'b1;
            neg      <= 1'b0;
            err_flag <= in_err;
          end
        end
        ADD: begin
          w_sr <= w_shifted;
          a_sr <= a_sr >> BCD_W;
          b_sr <= b_sr >> BCD_W;
          if (last) begin
            idx   <= '0;
            carry <= 1'b1;
            neg   <= ~add_cout;
          end else begin
            idx   <= idx + IDX_W'(1);
            carry <= add_cout;
          end
        end
        RECOMP: begin
          w_sr <= w_shifted;
          if (last) begin
            idx   <= '0;
            carry <= 1'b1;
          end else begin
            idx   <= idx + IDX_W'(1);
            carry <= add_cout;
          end
        end
        DONE: begin
          Result <= err_flag ? '0 : w_sr;
          Sign   <= err_flag ? 1'b0 : neg;
          Err    <= err_flag;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
